// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampling UART receiver.
// Frame format: start (low), DATA_SIZE bits LSB first, one stop (high).
// Every decision uses the synchronized line rx_s. A frame only starts on a
// low that follows a genuine high sample, so a line that is already low
// after reset is treated like a break rather than a start edge.
module uart_frame_rx #(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int DATA_SIZE      = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 new_data_out,
  output logic                 frame_err_out,
  output logic                 busy_out
);

  localparam int BAUD_W = $clog2(CLK_BAUD_RATIO);
  localparam int BIT_W  = $clog2(DATA_SIZE + 1);

  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  // Last baud count of a bit period: sample points are exactly one period apart.
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_BAUD_RATIO - 1);
  // START is entered one cycle after the edge, so mid-bit is one count earlier.
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLK_BAUD_RATIO / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_SIZE-1:0]  shift_q, shift_d;
  logic [DATA_SIZE-1:0]  data_q, data_d;
  logic                  new_data_q, new_data_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;
  logic                  sync_meta_q, sync_meta_d;
  logic                  sync_q, sync_d;
  // warm_q[1] marks that the synchronizer holds real line samples, not reset ones.
  logic [1:0]            warm_q, warm_d;
  // armed_q: a genuine high has been seen, so a following low is a start edge.
  logic                  armed_q, armed_d;
  logic                  rx_s;

  assign rx_s = sync_q;

  // Synchronizer chain and start-edge qualification.
  always_comb begin
    sync_meta_d = rx_in;
    sync_d      = sync_meta_q;
    warm_d      = {warm_q[0], 1'b1};
    armed_d     = armed_q | (warm_q[1] & rx_s);
  end

  // Frame FSM: next state, counters, shift register and output pulses.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = BAUD_ZERO;
        bit_d  = BIT_ZERO;
        if (armed_q && !rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_q == BAUD_MID) begin
          baud_d = BAUD_ZERO;
          bit_d  = BIT_ZERO;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = BAUD_ZERO;
          for (int i = 0; i < DATA_SIZE; i++) begin
            if (bit_q == BIT_W'(i)) begin
              shift_d[i] = rx_s;
            end else begin
              shift_d[i] = shift_q[i];
            end
          end
          if (bit_q == BIT_LAST) begin
            bit_d   = BIT_ZERO;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = BAUD_ZERO;
          if (rx_s) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = BIT_ZERO;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state and output registers; reset returns to a quiet idle receiver.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      baud_q      <= BAUD_ZERO;
      bit_q       <= BIT_ZERO;
      shift_q     <= {DATA_SIZE{1'b0}};
      data_q      <= {DATA_SIZE{1'b0}};
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      sync_meta_q <= 1'b1;
      sync_q      <= 1'b1;
      warm_q      <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
    end
  end

  assign data_out      = data_q;
  assign new_data_out  = new_data_q;
  assign frame_err_out = frame_err_q;
  assign busy_out      = busy_q;

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 Parameter CLK_BAUD_RATIO, default 25, clock cycles per bit period; legal values are integers of 4 or more.
REQ-002 Parameter DATA_SIZE, default 8, data bits per frame; legal range is 1 to 16.
REQ-003 clk_in  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 rx_in  input  1  serial line, asynchronous to clk_in, idle high; each frame is 1 start bit (low), DATA_SIZE data bits LSB first, 1 stop bit (high).
REQ-006 data_out  output  DATA_SIZE  last correctly framed word.
REQ-007 new_data_out  output  1  one-cycle pulse; data_out is valid in that cycle.
REQ-008 frame_err_out  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 busy_out  output  1  high in every state other than IDLE.

Function
REQ-010 rx_in shall pass through a 2-flop synchronizer (both flops reset to 1); all decisions shall use the synchronized value rx_s.
REQ-011 The FSM shall have the states IDLE, START, DATA, STOP and BREAK, plus a baud counter of width $clog2(CLK_BAUD_RATIO) and a bit counter of width $clog2(DATA_SIZE+1).
REQ-012 IDLE: when rx_s is low in cycle S, the FSM shall enter START with the baud counter cleared.
REQ-013 START: at cycle S+CLK_BAUD_RATIO/2 (integer division), if rx_s is low, go to DATA with both counters cleared; if rx_s is high, treat it as a glitch and return to IDLE with no pulse.
REQ-014 DATA: sample bit k (k = 0..DATA_SIZE-1) at cycle S+CLK_BAUD_RATIO/2+CLK_BAUD_RATIO*(k+1) into shift-register position k; after bit DATA_SIZE-1, go to STOP.
REQ-015 STOP: sample at cycle S+CLK_BAUD_RATIO/2+CLK_BAUD_RATIO*(DATA_SIZE+1).
- rx_s high: in the next cycle, load data_out from the shift register, pulse new_data_out, enter IDLE.
- rx_s low: in the next cycle, pulse frame_err_out, leave data_out unchanged, enter BREAK.
REQ-016 BREAK: remain until rx_s is high, then enter IDLE; a low line in BREAK shall never start a frame.
REQ-017 A start edge may be accepted in the first cycle of IDLE after STOP, so back-to-back frames with exactly one stop bit shall be received without loss.
REQ-018 new_data_out and frame_err_out shall never be high in the same cycle, and each frame shall produce at most one pulse.
REQ-019 data_out shall hold its value between pulses; the downstream multi-frame assembler captures it on the pulse only.
REQ-020 rx_in changes during DATA or STOP away from the sample points shall have no effect on any output.
REQ-021 The baud counter shall wrap from CLK_BAUD_RATIO-1 to 0 with no drift: each sample point is exactly CLK_BAUD_RATIO cycles after the previous one.
REQ-022 Latency: the last data bit reaches data_out exactly CLK_BAUD_RATIO+1 cycles after it is sampled.

Reset
REQ-023 While rst_in is high: state IDLE, counters 0, shift register 0, data_out 0, new_data_out 0, frame_err_out 0, busy_out 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame shall discard the partial frame; after release, with the line low, the block shall start a frame only after a low following a high sample (it enters IDLE but treats an already-low line as BREAK).
REQ-025 Reset release shall take effect synchronously to clk_in, with no pulse in the release cycle.

Verification
REQ-026 Defaults; send 0xA5 cleanly -> data_out=0xA5 and a single new_data_out pulse at cycle S+238, busy_out low from S+238 onward.
REQ-027 Send 0x00 then 0xFF back-to-back with 1 stop bit -> two pulses exactly 250 cycles apart, data_out 0x00 then 0xFF, no frame_err_out.
REQ-028 Drive a 5-cycle low glitch while IDLE -> FSM returns to IDLE at S+12, no pulse of either output, data_out unchanged.
REQ-029 Send 0x3C with the stop bit low, then hold the line low 100 cycles, then high -> one frame_err_out pulse, data_out keeps its prior value, no new frame starts until the line has returned high.
REQ-030 Assert rst_in during data bit 4 of 0x5A -> all outputs 0 immediately; the next clean 0x81 is received as 0x81.
REQ-031 CLK_BAUD_RATIO=4 and DATA_SIZE=16, send 0xBEEF -> data_out=0xBEEF, pulse at S+2+4*17+1.
